// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared raster geometry for the VGA front end and the renderer.
//   - 640x480@60 Hz porch / sync / visible constants for both axes
//   - derived totals and sync window bounds (start inclusive, end exclusive)
//   - coordinate width and CPU register-file geometry
//   - small helpers used by the axis counters
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Sync windows: [START, END)
    localparam int unsigned HSYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned HSYNC_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned VSYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned VSYNC_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam int unsigned COORD_W     = 11;

    // CPU register file as seen by the renderer
    localparam int unsigned NUM_REGS    = 10;
    localparam int unsigned REG_W       = 16;
    localparam int unsigned REGFILE_W   = NUM_REGS * REG_W;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [REGFILE_W-1:0] regfile_t;
    typedef logic [REG_W-1:0]     word_t;

    // Wrapping increment of an axis counter whose last legal value is 'last'.
    function automatic coord_t coord_advance(input coord_t value, input coord_t last);
        coord_t result;
        if (value == last) begin
            result = '0;
        end else begin
            result = value + coord_t'(1);
        end
        return result;
    endfunction

    // True when lo <= value < hi.
    function automatic logic coord_in_window(input coord_t value, input coord_t lo,
                                             input coord_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each enable
// and wraps. Sync and active flags are registered from the next-state count so
// they line up with 'count' on the same clock (no one-cycle skew).
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous, active-high reset (count = 0, sync_n = 1, active = 1)
//   enable  in   advance the counter this clock
//   count   out  current position, 0..TOTAL-1
//   wrap    out  combinational: enable is high and count is at TOTAL-1
//   sync_n  out  low while SYNC_START <= count < SYNC_END
//   active  out  high while count < VISIBLE
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752,
    parameter int unsigned VISIBLE    = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               sync_n,
    output logic               active
);

    localparam coord_t LAST     = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_LO  = coord_t'(SYNC_START);
    localparam coord_t SYNC_HI  = coord_t'(SYNC_END);
    localparam coord_t VIS_END  = coord_t'(VISIBLE);

    coord_t count_next;

    always_comb begin
        wrap       = enable && (count == LAST);
        count_next = count;
        if (enable) begin
            count_next = coord_advance(count, LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            sync_n <= 1'b1;
            active <= 1'b1;
        end else begin
            count  <= count_next;
            sync_n <= ~coord_in_window(count_next, SYNC_LO, SYNC_HI);
            active <= (count_next < VIS_END);
        end
    end

endmodule

// File: rtl/vga_timing_snapshot.sv
// -----------------------------------------------------------------------------
// vga_timing_snapshot
//
// Front end of the VGA renderer. Divides the system clock into a pixel strobe,
// runs the horizontal/vertical raster counters and produces sync/visible
// flags aligned with x/y. Also holds a frame-stable copy of the CPU register
// file and PC, refreshed only on entry to vertical blank so the renderer never
// draws a frame that mixes old and new register values.
//
// Ports
//   clk            in   system clock (only clock)
//   rst            in   synchronous, active-high reset
//   snap_en        in   1 = refresh snapshot at each vblank entry, 0 = hold
//   registers_in   in   live register file, NUM_REGS x REG_W
//   pc_in          in   live program counter
//   x, y           out  raster position
//   hsync, vsync   out  active-low syncs for the current x/y
//   visible        out  current x/y lies inside the visible area
//   pix_en         out  one-clock strobe per pixel period
//   frame_start    out  one-clock pulse when the raster wraps to (0, 0)
//   registers_out  out  snapshot of registers_in
//   pc_out         out  snapshot of pc_in
// -----------------------------------------------------------------------------
module vga_timing_snapshot
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV       = 2,
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          snap_en,
    input  logic [NUM_REGS*REG_W-1:0]     registers_in,
    input  logic [REG_W-1:0]              pc_in,
    output logic [COORD_W-1:0]            x,
    output logic [COORD_W-1:0]            y,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          visible,
    output logic                          pix_en,
    output logic                          frame_start,
    output logic [NUM_REGS*REG_W-1:0]     registers_out,
    output logic [REG_W-1:0]              pc_out
);

    localparam int unsigned H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = V_VISIBLE + V_FP + V_SYNC;

    // Divider is 3 bits wide, enough for DIV up to 8.
    localparam logic [2:0] DIV_LAST     = 3'(DIV - 1);
    localparam coord_t     V_LAST_VIS   = coord_t'(V_VISIBLE - 1);

    logic [2:0] div_cnt;
    logic [2:0] div_next;

    coord_t     h_count;
    coord_t     v_count;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_n;
    logic       v_sync_n;
    logic       h_active;
    logic       v_active;
    logic       v_enable;
    logic       snap_trig;

    // ---- pixel divider: pix_en registered from the next divider value ----
    always_comb begin
        div_next = div_cnt + 3'd1;
        if (div_cnt == DIV_LAST) begin
            div_next = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 3'd0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pix_en  <= (div_next == DIV_LAST);
        end
    end

    // ---- raster counters: vertical steps on the pixel that wraps x ----
    assign v_enable = pix_en & h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END),
        .VISIBLE    (H_VISIBLE)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .enable (pix_en),
        .count  (h_count),
        .wrap   (h_wrap),
        .sync_n (h_sync_n),
        .active (h_active)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END),
        .VISIBLE    (V_VISIBLE)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .enable (v_enable),
        .count  (v_count),
        .wrap   (v_wrap),
        .sync_n (v_sync_n),
        .active (v_active)
    );

    assign x       = h_count;
    assign y       = v_count;
    assign hsync   = h_sync_n;
    assign vsync   = v_sync_n;
    // Both flags are flops aligned with x/y, so their AND is skew-free.
    assign visible = h_active & v_active;

    // ---- frame pulse and snapshot: both fire on the stepping pixel ----
    // v_wrap is true only on the pix_en clock that takes (last, last) to
    // (0, 0), so the registered pulse lands on the first clock at (0, 0).
    // Reset clears it, so reset release never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap;
        end
    end

    // Last pixel of the last visible line: the raster is about to enter
    // vertical blank, so loading here keeps the visible region stable.
    assign snap_trig = h_wrap && (v_count == V_LAST_VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            registers_out <= '0;
            pc_out        <= '0;
        end else if (snap_trig && snap_en) begin
            registers_out <= registers_in;
            pc_out        <= pc_in;
        end
    end

endmodule

// File: tb/tb_vga_timing_snapshot.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_snapshot
//
// Directed bench for vga_timing_snapshot. Horizontal geometry is the real
// 800-pixel line; the vertical axis is shortened to 6 lines (2 visible,
// 1 front porch, 2 sync, 1 back porch) so whole frames fit in a short run.
// With DIV = 2 one frame is 800 * 6 * 2 = 9600 clocks.
// -----------------------------------------------------------------------------
module tb_vga_timing_snapshot;

    logic         clk = 1'b0;
    logic         rst;
    logic         snap_en;
    logic [159:0] registers_in;
    logic [15:0]  pc_in;
    logic [10:0]  x;
    logic [10:0]  y;
    logic         hsync;
    logic         vsync;
    logic         visible;
    logic         pix_en;
    logic         frame_start;
    logic [159:0] registers_out;
    logic [15:0]  pc_out;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [159:0] exp_regs;
    logic [15:0]  exp_pc;

    always #5 clk = ~clk;

    vga_timing_snapshot #(
        .DIV       (2),
        .V_VISIBLE (2),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .snap_en       (snap_en),
        .registers_in  (registers_in),
        .pc_in         (pc_in),
        .x             (x),
        .y             (y),
        .hsync         (hsync),
        .vsync         (vsync),
        .visible       (visible),
        .pix_en        (pix_en),
        .frame_start   (frame_start),
        .registers_out (registers_out),
        .pc_out        (pc_out)
    );

    // cyc = number of clock edges since reset release; pixel index = cyc / 2.
    function automatic logic [10:0] mx(input int c);
        return 11'((c / 2) % 800);
    endfunction

    function automatic logic [10:0] my(input int c);
        return 11'(((c / 2) / 800) % 6);
    endfunction

    // Edge that moves (799, 1) -> (0, 2): pixel 1600 of each 4800-pixel frame.
    function automatic logic is_trig(input int c);
        return (c > 0) && (c % 2 == 0) && (((c / 2) % 4800) == 1600);
    endfunction

    // Advance one clock; inputs were driven before the call and are sampled
    // on the coming edge.
    task automatic step();
        int nxt;
        nxt = cyc + 1;
        if (snap_en && is_trig(nxt)) begin
            exp_regs = registers_in;
            exp_pc   = pc_in;
        end
        @(negedge clk);
        cyc = nxt;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        snap_en      = 1'b1;
        registers_in = '1;
        pc_in        = '1;
        repeat (3) @(negedge clk);
        n_assert++; if (x !== 11'd0) begin n_fail++; $display("FAIL reset_x actual=%0d expected=0", x); end
        n_assert++; if (y !== 11'd0) begin n_fail++; $display("FAIL reset_y actual=%0d expected=0", y); end
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync actual=%b expected=1", hsync); end
        n_assert++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync actual=%b expected=1", vsync); end
        n_assert++; if (visible !== 1'b1) begin n_fail++; $display("FAIL reset_visible actual=%b expected=1", visible); end
        n_assert++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en actual=%b expected=0", pix_en); end
        n_assert++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start actual=%b expected=0", frame_start); end
        n_assert++; if (registers_out !== 160'd0) begin n_fail++; $display("FAIL reset_registers actual=%h expected=0", registers_out); end
        n_assert++; if (pc_out !== 16'd0) begin n_fail++; $display("FAIL reset_pc actual=%h expected=0", pc_out); end
        registers_in = '0;
        pc_in        = '0;
        rst          = 1'b0;
        cyc          = 0;
        exp_regs     = '0;
        exp_pc       = '0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 1600; i++) begin
            step();
            n_assert++;
            if (pix_en !== logic'(cyc % 2 == 1)) begin
                n_fail++; $display("FAIL free_pix_en cyc=%0d actual=%b expected=%b", cyc, pix_en, (cyc % 2 == 1));
            end
            n_assert++;
            if (x !== mx(cyc)) begin n_fail++; $display("FAIL free_x cyc=%0d actual=%0d expected=%0d", cyc, x, mx(cyc)); end
            n_assert++;
            if (y !== my(cyc)) begin n_fail++; $display("FAIL free_y cyc=%0d actual=%0d expected=%0d", cyc, y, my(cyc)); end
            n_assert++;
            if (frame_start !== 1'b0) begin n_fail++; $display("FAIL free_frame_start cyc=%0d actual=%b expected=0", cyc, frame_start); end
            if (cyc == 1599) begin
                n_assert++;
                if (x !== 11'd799) begin n_fail++; $display("FAIL line_end_x actual=%0d expected=799", x); end
            end
        end
        n_assert++; if (x !== 11'd0) begin n_fail++; $display("FAIL line_wrap_x actual=%0d expected=0", x); end
        n_assert++; if (y !== 11'd1) begin n_fail++; $display("FAIL line_wrap_y actual=%0d expected=1", y); end
    endtask

    task automatic test_hsync();
        logic exp_hs;
        logic exp_vis;
        int   hs_low;
        hs_low = 0;
        for (int i = 0; i < 1600; i++) begin
            step();
            exp_hs  = !(mx(cyc) >= 11'd656 && mx(cyc) < 11'd752);
            exp_vis = (mx(cyc) < 11'd640) && (my(cyc) < 11'd2);
            if (hsync === 1'b0) hs_low++;
            n_assert++;
            if (hsync !== exp_hs) begin n_fail++; $display("FAIL hsync cyc=%0d x=%0d actual=%b expected=%b", cyc, x, hsync, exp_hs); end
            n_assert++;
            if (visible !== exp_vis) begin n_fail++; $display("FAIL visible cyc=%0d x=%0d actual=%b expected=%b", cyc, x, visible, exp_vis); end
            n_assert++;
            if (x !== mx(cyc)) begin n_fail++; $display("FAIL hs_x cyc=%0d actual=%0d expected=%0d", cyc, x, mx(cyc)); end
        end
        n_assert++;
        if (hs_low != 192) begin n_fail++; $display("FAIL hsync_width actual=%0d expected=192", hs_low); end
    endtask

    task automatic test_full_frame();
        logic exp_vs;
        int   fs_cnt;
        int   vs_low;
        fs_cnt = 0;
        vs_low = 0;
        for (int i = 0; i < 9600; i++) begin
            step();
            exp_vs = !(my(cyc) >= 11'd3 && my(cyc) < 11'd5);
            if (frame_start === 1'b1) fs_cnt++;
            if (vsync === 1'b0) vs_low++;
            n_assert++;
            if (frame_start !== logic'(cyc % 9600 == 0)) begin
                n_fail++; $display("FAIL frame_start cyc=%0d actual=%b expected=%b", cyc, frame_start, (cyc % 9600 == 0));
            end
            n_assert++;
            if (vsync !== exp_vs) begin n_fail++; $display("FAIL vsync cyc=%0d y=%0d actual=%b expected=%b", cyc, y, vsync, exp_vs); end
            n_assert++;
            if (y !== my(cyc)) begin n_fail++; $display("FAIL frame_y cyc=%0d actual=%0d expected=%0d", cyc, y, my(cyc)); end
        end
        n_assert++;
        if (fs_cnt != 1) begin n_fail++; $display("FAIL frame_start_count actual=%0d expected=1", fs_cnt); end
        n_assert++;
        if (vs_low != 3200) begin n_fail++; $display("FAIL vsync_width actual=%0d expected=3200", vs_low); end
    endtask

    task automatic test_snapshot();
        snap_en = 1'b1;
        while (cyc < 22404) begin
            if (is_trig(cyc + 1)) begin
                registers_in = {10{16'hA5A5}};
                pc_in        = 16'h1234;
            end else begin
                registers_in = {10{16'(cyc) ^ 16'h5A3C}};
                pc_in        = 16'(cyc);
            end
            if (cyc == 22399) begin
                n_assert++;
                if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL snap_pre_pc actual=%h expected=0000", pc_out); end
            end
            step();
            n_assert++;
            if (registers_out !== exp_regs) begin n_fail++; $display("FAIL snap_regs cyc=%0d actual=%h expected=%h", cyc, registers_out, exp_regs); end
            n_assert++;
            if (pc_out !== exp_pc) begin n_fail++; $display("FAIL snap_pc cyc=%0d actual=%h expected=%h", cyc, pc_out, exp_pc); end
            if (cyc == 22400) begin
                n_assert++;
                if (pc_out !== 16'h1234) begin n_fail++; $display("FAIL snap_load_pc actual=%h expected=1234", pc_out); end
                n_assert++;
                if (registers_out !== {10{16'hA5A5}}) begin n_fail++; $display("FAIL snap_load_regs actual=%h expected=a5a5...", registers_out); end
                n_assert++;
                if (y !== 11'd2 || x !== 11'd0) begin n_fail++; $display("FAIL snap_pos actual=(%0d,%0d) expected=(0,2)", x, y); end
            end
        end
    endtask

    task automatic test_freeze();
        snap_en = 1'b0;
        while (cyc < 51204) begin
            if (cyc == 39000) snap_en = 1'b1;
            if (cyc == 40000) snap_en = 1'b0;
            if (cyc == 49000) snap_en = 1'b1;
            if (cyc > 49000 && is_trig(cyc + 1)) begin
                registers_in = {10{16'h0F0F}};
                pc_in        = 16'hBEEF;
            end else begin
                registers_in = {10{16'(cyc) ^ 16'hC3C3}};
                pc_in        = 16'(cyc) + 16'h0101;
            end
            step();
            n_assert++;
            if (registers_out !== exp_regs) begin n_fail++; $display("FAIL freeze_regs cyc=%0d actual=%h expected=%h", cyc, registers_out, exp_regs); end
            n_assert++;
            if (pc_out !== exp_pc) begin n_fail++; $display("FAIL freeze_pc cyc=%0d actual=%h expected=%h", cyc, pc_out, exp_pc); end
            if (cyc == 32001 || cyc == 41601 || cyc == 51199) begin
                n_assert++;
                if (pc_out !== 16'h1234) begin n_fail++; $display("FAIL freeze_hold_pc cyc=%0d actual=%h expected=1234", cyc, pc_out); end
            end
            if (cyc == 51200) begin
                n_assert++;
                if (pc_out !== 16'hBEEF) begin n_fail++; $display("FAIL resume_pc actual=%h expected=beef", pc_out); end
                n_assert++;
                if (registers_out !== {10{16'h0F0F}}) begin n_fail++; $display("FAIL resume_regs actual=%h expected=0f0f...", registers_out); end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        int guard;
        guard        = 0;
        registers_in = {10{16'h7777}};
        pc_in        = 16'h4321;
        while (!(mx(cyc) == 11'd300 && my(cyc) == 11'd1) && guard < 20000) begin
            step();
            guard++;
        end
        n_assert++;
        if (guard >= 20000) begin n_fail++; $display("FAIL mid_reset_seek actual=%0d expected<20000", guard); end
        n_assert++;
        if (x !== 11'd300 || y !== 11'd1) begin n_fail++; $display("FAIL mid_reset_pos actual=(%0d,%0d) expected=(300,1)", x, y); end
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (x !== 11'd0) begin n_fail++; $display("FAIL mid_reset_x actual=%0d expected=0", x); end
        n_assert++; if (y !== 11'd0) begin n_fail++; $display("FAIL mid_reset_y actual=%0d expected=0", y); end
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL mid_reset_hsync actual=%b expected=1", hsync); end
        n_assert++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL mid_reset_vsync actual=%b expected=1", vsync); end
        n_assert++; if (pc_out !== 16'd0) begin n_fail++; $display("FAIL mid_reset_pc actual=%h expected=0", pc_out); end
        n_assert++; if (registers_out !== 160'd0) begin n_fail++; $display("FAIL mid_reset_regs actual=%h expected=0", registers_out); end
        n_assert++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_reset_frame_start actual=%b expected=0", frame_start); end
        n_assert++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pix_en actual=%b expected=0", pix_en); end
        rst      = 1'b0;
        cyc      = 0;
        exp_regs = '0;
        exp_pc   = '0;
        for (int i = 0; i < 1700; i++) begin
            step();
            n_assert++;
            if (x !== mx(cyc) || y !== my(cyc)) begin
                n_fail++; $display("FAIL resume_xy cyc=%0d actual=(%0d,%0d) expected=(%0d,%0d)", cyc, x, y, mx(cyc), my(cyc));
            end
            n_assert++;
            if (frame_start !== 1'b0) begin n_fail++; $display("FAIL resume_frame_start cyc=%0d actual=%b expected=0", cyc, frame_start); end
            n_assert++;
            if (pc_out !== exp_pc) begin n_fail++; $display("FAIL resume_snap_pc cyc=%0d actual=%h expected=%h", cyc, pc_out, exp_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_hsync();
        test_full_frame();
        test_snapshot();
        test_freeze();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t expected finish before 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
